// File: rtl/seq_detect_scheduler.sv
// Time-shares one Mealy sequence-detector engine between NCH bit-serial channels with round-robin slices and per-channel context save/restore.
// Optional: define SEQSCHED_MATCH_CNT_EN to add per-channel saturating match counters.
module seq_detect_scheduler #(
    parameter int NCH   = 4,
    parameter int SLICE = 8,
    parameter int STW   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NCH-1:0]   i_req,
    input  logic [NCH-1:0]   i_ch_din,
    input  logic [NCH-1:0]   i_ch_vld,
    output logic [NCH-1:0]   o_ch_rdy,
    output logic [NCH-1:0]   o_grant,
    output logic             o_det_load,
    output logic [STW-1:0]   o_det_state_wr,
    input  logic [STW-1:0]   i_det_state_rd,
    output logic             o_det_vld,
    output logic             o_det_din,
    input  logic             i_det_dout,
    output logic [NCH-1:0]   o_match
`ifdef SEQSCHED_MATCH_CNT_EN
    ,
    input  logic [$clog2(NCH)-1:0] i_cnt_sel,
    input  logic                   i_cnt_clr,
    output logic [7:0]             o_cnt_out
`endif
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_SAVE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_sel;
    logic [PW-1:0]  r_ptr;
    logic [7:0]     r_cnt;
    logic [STW-1:0] r_ctx [NCH];
    logic [NCH-1:0] r_match;

    logic [PW-1:0]  w_base;
    logic [PW-1:0]  w_idx;
    logic [PW-1:0]  w_pick;
    logic           w_pick_vld;
    logic           w_acc;

    // In SAVE the pointer updates on this same edge, so arbitrate from the outgoing owner
    always_comb begin
        w_base     = (r_state == S_SAVE) ? r_sel : r_ptr;
        w_idx      = '0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            w_idx = PW'((int'(w_base) + k) % NCH);
            if (i_req[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_grant        = '0;
        o_ch_rdy       = '0;
        o_det_load     = 1'b0;
        o_det_state_wr = r_ctx[r_sel];
        o_det_vld      = 1'b0;
        o_det_din      = 1'b0;
        w_acc          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                o_grant[r_sel] = 1'b1;
                o_det_load     = 1'b1;
                w_state_nxt    = S_RUN;
            end
            S_RUN: begin
                o_grant[r_sel]  = 1'b1;
                o_ch_rdy[r_sel] = i_req[r_sel];
                w_acc           = i_req[r_sel] && i_ch_vld[r_sel];
                o_det_vld       = w_acc;
                o_det_din       = w_acc && i_ch_din[r_sel];
                if (!i_req[r_sel]) begin
                    w_state_nxt = S_SAVE;
                end else if (w_acc && (r_cnt == 8'(SLICE - 1))) begin
                    w_state_nxt = S_SAVE;
                end
            end
            S_SAVE: begin
                o_grant[r_sel] = 1'b1;
                w_state_nxt    = w_pick_vld ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel   <= '0;
            r_ptr   <= PW'(NCH - 1);
            r_cnt   <= '0;
            r_match <= '0;
            for (int i = 0; i < NCH; i++) r_ctx[i] <= '0;
        end else begin
            r_match <= '0;
            if (o_det_vld) r_match[r_sel] <= i_det_dout;
            case (r_state)
                S_IDLE: if (w_pick_vld) r_sel <= w_pick;
                S_LOAD: r_cnt <= '0;
                S_RUN:  if (w_acc) r_cnt <= r_cnt + 8'd1;
                S_SAVE: begin
                    r_ctx[r_sel] <= i_det_state_rd;
                    r_ptr        <= r_sel;
                    if (w_pick_vld) r_sel <= w_pick;
                end
                default: ;
            endcase
        end
    end

    assign o_match = r_match;

`ifdef SEQSCHED_MATCH_CNT_EN
    logic [7:0] r_mcnt [NCH];

    // Counts registered match pulses; a clear in the same cycle takes priority
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCH; i++) r_mcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (i_cnt_clr && (i_cnt_sel == PW'(i))) begin
                    r_mcnt[i] <= '0;
                end else if (r_match[i] && (r_mcnt[i] != 8'hFF)) begin
                    r_mcnt[i] <= r_mcnt[i] + 8'd1;
                end
            end
        end
    end

    assign o_cnt_out = r_mcnt[i_cnt_sel];
`endif

endmodule
